// File: rtl/mem_master.sv
// mem_master: single/burst read-write initiator for the single-port data memory.
// Define MEM_MASTER_BOUNDS_CHECK_EN to reject requests that run past MEM_LEN instead of wrapping.
module mem_master #(
  parameter  int DATA_W    = 32,
  parameter  int MEM_LEN   = 512,
  parameter  int MAX_BURST = 16,
  localparam int ADDR_W    = $clog2(MEM_LEN),
  localparam int LEN_W     = $clog2(MAX_BURST) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_OUT,
    WR_WAIT,
    WR_DRIVE,
    DONE
  } state_e;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  i_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              rd_valid_q;
  logic              rd_last_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              done_q;
  logic              err_q;

  logic [LEN_W-1:0]  iNext;
  logic              lastBeat;
  logic              reqBad;

  assign iNext    = i_q + LEN_W'(1);
  assign lastBeat = (iNext == len_q);

`ifdef MEM_MASTER_BOUNDS_CHECK_EN
  // Widened so base + len can never overflow before the compare.
  logic [ADDR_W+LEN_W-1:0] reqEnd;
  assign reqEnd = (ADDR_W+LEN_W)'(req_addr) + (ADDR_W+LEN_W)'(req_len);
`endif

  always_comb begin
    reqBad = (req_len == '0) || (req_len > MAX_LEN);
`ifdef MEM_MASTER_BOUNDS_CHECK_EN
    if (reqEnd > (ADDR_W+LEN_W)'(MEM_LEN)) begin
      reqBad = 1'b1;
    end
`endif
  end

  // Status decodes come straight from state so req_ready rises the cycle rst falls.
  assign req_ready = (state_q == IDLE) && !rst;
  assign wr_ready  = (state_q == WR_WAIT);
  assign busy      = (state_q != IDLE);

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      i_q         <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            base_q <= req_addr;
            len_q  <= req_len;
            i_q    <= '0;
            if (reqBad) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (req_we) begin
              state_q <= WR_WAIT;
            end else begin
              state_q    <= RD_ADDR;
              mem_addr_q <= req_addr;
            end
          end
        end
        // Memory reads combinationally; data is sampled at the end of the address cycle.
        RD_ADDR: begin
          rd_data_q  <= mem_rdata;
          rd_valid_q <= 1'b1;
          rd_last_q  <= lastBeat;
          state_q    <= RD_OUT;
        end
        RD_OUT: begin
          if (rd_ready) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            i_q        <= iNext;
            if (lastBeat) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= RD_ADDR;
              mem_addr_q <= base_q + ADDR_W'(iNext);
            end
          end
        end
        WR_WAIT: begin
          if (wr_valid) begin
            mem_wdata_q <= wr_data;
            mem_addr_q  <= base_q + ADDR_W'(i_q);
            mem_we_q    <= 1'b1;
            state_q     <= WR_DRIVE;
          end
        end
        WR_DRIVE: begin
          i_q <= iNext;
          if (lastBeat) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= WR_WAIT;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: randomized self-checking bench for mem_master against a word-array memory model.
// Honours MEM_MASTER_BOUNDS_CHECK_EN when deciding which requests must be rejected.
module tb_mem_master;

  localparam int DATA_W    = 32;
  localparam int MEM_LEN   = 512;
  localparam int MAX_BURST = 16;
  localparam int ADDR_W    = 9;
  localparam int LEN_W     = 5;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // mem is the memory the DUT drives; refMem is what the words should be.
  logic [DATA_W-1:0] mem     [MEM_LEN];
  logic [DATA_W-1:0] refMem  [MEM_LEN];
  logic [DATA_W-1:0] wrBeats [MAX_BURST];

  int checkCount = 0;
  int errCount   = 0;
  int fixedStall = -1;

  mem_master dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance to the next falling edge; a strobe still high there is committed to memory.
  task automatic nextCycle();
    @(negedge clk);
    if (mem_we) mem[mem_addr] = mem_wdata;
  endtask

  function automatic int pickStall();
    return (fixedStall >= 0) ? fixedStall : int'($urandom_range(0, 3));
  endfunction

  // One full request from handshake to the return to IDLE, with per-cycle expectations.
  task automatic applyStimulus(input logic we, input int addr, input int len);
    logic legal;
    int   a;
    int   stall;
    legal = (len >= 1) && (len <= MAX_BURST);
`ifdef MEM_MASTER_BOUNDS_CHECK_EN
    if (addr + len > MEM_LEN) legal = 1'b0;
`endif
    checkOutput("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = ADDR_W'(addr);
    req_len   = LEN_W'(len);
    nextCycle();
    req_valid = 1'b0;

    if (!legal) begin
      checkOutput("rej_done", 32'(done), 32'd1);
      checkOutput("rej_err", 32'(err), 32'd1);
      checkOutput("rej_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rej_req_ready", 32'(req_ready), 32'd0);
      nextCycle();
      checkOutput("rej_done_clear", 32'(done), 32'd0);
      checkOutput("rej_err_clear", 32'(err), 32'd0);
      return;
    end

    for (int k = 0; k < len; k++) begin
      a = (addr + k) % MEM_LEN;
      if (!we) begin
        checkOutput("rd_addr_valid_low", 32'(rd_valid), 32'd0);
        checkOutput("rd_mem_addr", 32'(mem_addr), 32'(a));
        checkOutput("rd_mem_we_low", 32'(mem_we), 32'd0);
        rd_ready = 1'($urandom_range(0, 1));
        nextCycle();
        checkOutput("rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("rd_data", rd_data, refMem[a]);
        checkOutput("rd_last", 32'(rd_last), 32'(k == len - 1));
        stall = pickStall();
        for (int s = 0; s < stall; s++) begin
          rd_ready = 1'b0;
          nextCycle();
          checkOutput("rd_stall_valid", 32'(rd_valid), 32'd1);
          checkOutput("rd_stall_data", rd_data, refMem[a]);
          checkOutput("rd_stall_addr", 32'(mem_addr), 32'(a));
        end
        rd_ready = 1'b1;
        nextCycle();
        rd_ready = 1'b0;
      end else begin
        checkOutput("wr_ready", 32'(wr_ready), 32'd1);
        checkOutput("wr_wait_we_low", 32'(mem_we), 32'd0);
        stall = pickStall();
        for (int s = 0; s < stall; s++) begin
          wr_valid = 1'b0;
          nextCycle();
          checkOutput("wr_stall_ready", 32'(wr_ready), 32'd1);
          checkOutput("wr_stall_we_low", 32'(mem_we), 32'd0);
        end
        wr_valid = 1'b1;
        wr_data  = wrBeats[k];
        nextCycle();
        checkOutput("wr_mem_we", 32'(mem_we), 32'd1);
        checkOutput("wr_mem_addr", 32'(mem_addr), 32'(a));
        checkOutput("wr_mem_wdata", mem_wdata, wrBeats[k]);
        checkOutput("wr_drive_ready_low", 32'(wr_ready), 32'd0);
        refMem[a] = wrBeats[k];
        wr_valid = 1'($urandom_range(0, 1));
        wr_data  = $urandom;
        nextCycle();
      end
    end

    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_err", 32'(err), 32'd0);
    checkOutput("done_mem_we", 32'(mem_we), 32'd0);
    checkOutput("done_req_ready", 32'(req_ready), 32'd0);
    checkOutput("done_busy", 32'(busy), 32'd1);
    nextCycle();
    checkOutput("post_done_clear", 32'(done), 32'd0);
    checkOutput("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int addr;
    int len;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;
    for (int i = 0; i < MEM_LEN; i++) begin
      mem[i]    = $urandom;
      refMem[i] = mem[i];
    end

    nextCycle();
    nextCycle();
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
    rst = 1'b0;
    nextCycle();
    checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("post_rst_done", 32'(done), 32'd0);

    // Read burst of a known pattern with the consumer always ready.
    for (int i = 0; i < 3; i++) begin
      mem[4 + i]    = 32'(4 + i);
      refMem[4 + i] = 32'(4 + i);
    end
    fixedStall = 0;
    applyStimulus(1'b0, 4, 3);

    // Write two words and read them back.
    wrBeats[0] = 32'hDEADBEEF;
    wrBeats[1] = 32'h12345678;
    applyStimulus(1'b1, 10, 2);
    applyStimulus(1'b0, 10, 2);

    // Consumer backpressure holds each beat for five cycles.
    fixedStall = 5;
    applyStimulus(1'b0, 100, 2);
    fixedStall = -1;

    // Zero and oversized lengths are rejected without touching memory.
    applyStimulus(1'b0, 8, 0);
    applyStimulus(1'b1, 8, 17);

    // Burst crossing the top of memory: wraps, or is rejected with the bounds check.
    applyStimulus(1'b0, 510, 4);

    // Reset during the strobe of beat 2 of 4 aborts the burst silently.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = ADDR_W'(200);
    req_len   = LEN_W'(4);
    nextCycle();
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hA5A50000 + 32'(k);
      nextCycle();
      checkOutput("abort_mem_we", 32'(mem_we), 32'd1);
      checkOutput("abort_mem_addr", 32'(mem_addr), 32'(200 + k));
      refMem[200 + k] = 32'hA5A50000 + 32'(k);
      wr_valid = 1'b0;
      if (k == 0) nextCycle();
    end
    rst = 1'b1;
    nextCycle();
    checkOutput("abort_we_low", 32'(mem_we), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_no_done", 32'(done), 32'd0);
    checkOutput("abort_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("abort_req_ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    nextCycle();
    checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_busy_after", 32'(busy), 32'd0);
    checkOutput("abort_done_after", 32'(done), 32'd0);
    applyStimulus(1'b0, 198, 6);

    // Random mix, biased toward the top of memory and illegal lengths.
    for (int t = 0; t < 60; t++) begin
      addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(500, 511)) : int'($urandom_range(0, 511));
      len  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, 16));
      for (int b = 0; b < MAX_BURST; b++) wrBeats[b] = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), addr, len);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
